axi4_lite_skid_slice: RTL

Full-throughput register slice for one AXI4-lite link, placed directly upstream of the bus sunder to break timing between the interconnect master and the sunder's address-decode logic. Each of the five channels (AW, W, B, AR, R) gets an independent two-entry skid buffer, so every valid, ready and payload signal crossing the block is driven from a flop. Transactions pass through unmodified and in order, at one beat per cycle per channel.

---
 rtl/axi4_lite_skid_slice.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_skid_slice.sv
// AXI4-lite register slice: one two-entry skid buffer per channel so every valid,
// ready and payload bit leaving the block comes straight from a flop.
package axi4_lite_pkg;
  typedef struct packed {
    int unsigned A;
    int unsigned N;
  } axi4_lite_cfg_t;
endpackage

interface axi4_lite_if #(
  parameter int unsigned A = 32,
  parameter int unsigned N = 4
);
  logic             awvalid;
  logic             awready;
  logic [A-1:0]     awaddr;
  logic [2:0]       awprot;
  logic             wvalid;
  logic             wready;
  logic [8*N-1:0]   wdata;
  logic [N-1:0]     wstrb;
  logic             bvalid;
  logic             bready;
  logic [1:0]       bresp;
  logic             arvalid;
  logic             arready;
  logic [A-1:0]     araddr;
  logic [2:0]       arprot;
  logic             rvalid;
  logic             rready;
  logic [8*N-1:0]   rdata;
  logic [1:0]       rresp;

  modport master (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bresp, output bready,
    output arvalid, araddr, arprot, input arready,
    input rvalid, rdata, rresp, output rready
  );

  modport slave (
    input awvalid, awaddr, awprot, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp, input rready
  );
endinterface

module axi4_lite_skid_buf #(
  parameter int unsigned W      = 8,
  parameter bit          BYPASS = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         src_valid,
  output logic         src_ready,
  input  logic [W-1:0] src_data,
  output logic         snk_valid,
  input  logic         snk_ready,
  output logic [W-1:0] snk_data
);
  if (BYPASS) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign snk_valid      = src_valid;
    assign snk_data       = src_data;
    assign src_ready      = snk_ready;
  end else begin : g_reg
    // Encoding puts m_vld on bit 0 and s_vld on bit 1, so both are raw flop outputs.
    typedef enum logic [1:0] {
      EMPTY = 2'b00,
      BUSY  = 2'b01,
      FULL  = 2'b11
    } state_t;

    state_t       state;
    logic [W-1:0] m_data;
    logic [W-1:0] s_data;
    logic         rdy;
    logic         in_xfer;
    logic         out_xfer;
    logic         s_vld_next;

    assign in_xfer    = src_valid & rdy;
    assign out_xfer   = state[0] & snk_ready;
    assign s_vld_next = (state == FULL) ? !out_xfer
                                        : ((state == BUSY) && in_xfer && !out_xfer);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state  <= EMPTY;
        m_data <= '0;
        s_data <= '0;
        rdy    <= 1'b0;
      end else begin
        rdy <= !s_vld_next;
        case (state)
          EMPTY: begin
            if (in_xfer) begin
              state  <= BUSY;
              m_data <= src_data;
            end
          end
          BUSY: begin
            if (in_xfer && out_xfer) begin
              m_data <= src_data;
            end else if (in_xfer) begin
              state  <= FULL;
              s_data <= src_data;
            end else if (out_xfer) begin
              state <= EMPTY;
            end
          end
          FULL: begin
            if (out_xfer) begin
              state  <= BUSY;
              m_data <= s_data;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end

    assign snk_valid = state[0];
    assign snk_data  = m_data;
    assign src_ready = rdy;
  end
endmodule

module axi4_lite_skid_slice #(
  parameter axi4_lite_pkg::axi4_lite_cfg_t C    = '{A: 32, N: 4},
  parameter logic [4:0]                    PASS = 5'b00000
) (
  input logic         aclk,
  input logic         areset,
  axi4_lite_if.slave  axi4_s,
  axi4_lite_if.master axi4_m
);
  localparam int unsigned AW = C.A;
  localparam int unsigned DW = 8 * C.N;
  localparam int unsigned SW = C.N;

  logic [AW+2:0]    aw_in, aw_out;
  logic [DW+SW-1:0] w_in, w_out;
  logic [1:0]       b_in, b_out;
  logic [AW+2:0]    ar_in, ar_out;
  logic [DW+1:0]    r_in, r_out;

  assign aw_in = {axi4_s.awaddr, axi4_s.awprot};
  assign {axi4_m.awaddr, axi4_m.awprot} = aw_out;
  assign w_in  = {axi4_s.wdata, axi4_s.wstrb};
  assign {axi4_m.wdata, axi4_m.wstrb} = w_out;
  assign b_in  = axi4_m.bresp;
  assign axi4_s.bresp = b_out;
  assign ar_in = {axi4_s.araddr, axi4_s.arprot};
  assign {axi4_m.araddr, axi4_m.arprot} = ar_out;
  assign r_in  = {axi4_m.rdata, axi4_m.rresp};
  assign {axi4_s.rdata, axi4_s.rresp} = r_out;

  // Request channels flow upstream -> downstream.
  axi4_lite_skid_buf #(.W(AW + 3), .BYPASS(PASS[0])) u_aw (
    .clk(aclk), .rst(areset),
    .src_valid(axi4_s.awvalid), .src_ready(axi4_s.awready), .src_data(aw_in),
    .snk_valid(axi4_m.awvalid), .snk_ready(axi4_m.awready), .snk_data(aw_out)
  );

  axi4_lite_skid_buf #(.W(DW + SW), .BYPASS(PASS[1])) u_w (
    .clk(aclk), .rst(areset),
    .src_valid(axi4_s.wvalid), .src_ready(axi4_s.wready), .src_data(w_in),
    .snk_valid(axi4_m.wvalid), .snk_ready(axi4_m.wready), .snk_data(w_out)
  );

  axi4_lite_skid_buf #(.W(AW + 3), .BYPASS(PASS[3])) u_ar (
    .clk(aclk), .rst(areset),
    .src_valid(axi4_s.arvalid), .src_ready(axi4_s.arready), .src_data(ar_in),
    .snk_valid(axi4_m.arvalid), .snk_ready(axi4_m.arready), .snk_data(ar_out)
  );

  // Response channels flow downstream -> upstream.
  axi4_lite_skid_buf #(.W(2), .BYPASS(PASS[2])) u_b (
    .clk(aclk), .rst(areset),
    .src_valid(axi4_m.bvalid), .src_ready(axi4_m.bready), .src_data(b_in),
    .snk_valid(axi4_s.bvalid), .snk_ready(axi4_s.bready), .snk_data(b_out)
  );

  axi4_lite_skid_buf #(.W(DW + 2), .BYPASS(PASS[4])) u_r (
    .clk(aclk), .rst(areset),
    .src_valid(axi4_m.rvalid), .src_ready(axi4_m.rready), .src_data(r_in),
    .snk_valid(axi4_s.rvalid), .snk_ready(axi4_s.rready), .snk_data(r_out)
  );
endmodule
